// File: rtl/mam_req_arbiter.sv
// Round-robin arbiter sharing one MAM memory-access port between NUM_PORTS requesters.
// Ownership lasts from request accept until the last data beat; data paths are a pure mux on the grant.
module mam_req_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             CLK_I,
  input  logic                             RST_I,
  input  logic [NUM_PORTS-1:0]             s_req_valid,
  output logic [NUM_PORTS-1:0]             s_req_ready,
  input  logic [NUM_PORTS-1:0]             s_req_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_req_addr,
  input  logic [NUM_PORTS-1:0]             s_req_burst,
  input  logic [NUM_PORTS*14-1:0]          s_req_beats,
  input  logic [NUM_PORTS-1:0]             s_write_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_write_data,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_write_strb,
  output logic [NUM_PORTS-1:0]             s_write_ready,
  output logic [NUM_PORTS-1:0]             s_read_valid,
  output logic [DATA_WIDTH-1:0]            s_read_data,
  input  logic [NUM_PORTS-1:0]             s_read_ready,
  output logic                             m_req_valid,
  input  logic                             m_req_ready,
  output logic                             m_req_rw,
  output logic [ADDR_WIDTH-1:0]            m_req_addr,
  output logic                             m_req_burst,
  output logic [13:0]                      m_req_beats,
  output logic                             m_write_valid,
  output logic [DATA_WIDTH-1:0]            m_write_data,
  output logic [DATA_WIDTH/8-1:0]          m_write_strb,
  input  logic                             m_write_ready,
  input  logic                             m_read_valid,
  input  logic [DATA_WIDTH-1:0]            m_read_data,
  output logic                             m_read_ready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             busy
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WRITE, ST_READ} state_t;

  state_t         state;
  logic [IW-1:0]  gidx;
  logic [IW-1:0]  rr_ptr;
  logic [13:0]    beats_left;

  logic                  sel_req_valid, sel_rw, sel_burst, sel_write_valid, sel_read_ready;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [13:0]           sel_beats;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [SW-1:0]         sel_wstrb;

  logic                  arb_found;
  logic [IW-1:0]         arb_idx;
  logic [IW-1:0]         arb_cand;
  logic [NUM_PORTS-1:0]  arb_onehot;
  logic [IW-1:0]         rr_next;
  logic                  req_hs, wr_hs, rd_hs;

  // Search upward from rr_ptr with wrap; the candidate index wraps at NUM_PORTS, not at 2**IW.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    arb_cand   = rr_ptr;
    arb_onehot = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!arb_found && s_req_valid[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
      arb_cand = (arb_cand == IW'(NUM_PORTS - 1)) ? '0 : arb_cand + 1'b1;
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      arb_onehot[i] = (arb_idx == IW'(i));
  end

  assign rr_next = (gidx == IW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    sel_req_valid   = 1'b0;
    sel_rw          = 1'b0;
    sel_burst       = 1'b0;
    sel_write_valid = 1'b0;
    sel_read_ready  = 1'b0;
    sel_addr        = '0;
    sel_beats       = '0;
    sel_wdata       = '0;
    sel_wstrb       = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gidx == IW'(i)) begin
        sel_req_valid   = s_req_valid[i];
        sel_rw          = s_req_rw[i];
        sel_burst       = s_req_burst[i];
        sel_write_valid = s_write_valid[i];
        sel_read_ready  = s_read_ready[i];
        sel_addr        = s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_beats       = s_req_beats[i*14 +: 14];
        sel_wdata       = s_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb       = s_write_strb[i*SW +: SW];
      end
    end
  end

  assign req_hs = (state == ST_REQ)   && sel_req_valid   && m_req_ready;
  assign wr_hs  = (state == ST_WRITE) && sel_write_valid && m_write_ready;
  assign rd_hs  = (state == ST_READ)  && m_read_valid    && sel_read_ready;

  assign s_read_data = m_read_data;

  always_comb begin
    m_req_valid   = 1'b0;
    m_req_rw      = 1'b0;
    m_req_addr    = '0;
    m_req_burst   = 1'b0;
    m_req_beats   = '0;
    m_write_valid = 1'b0;
    m_write_data  = '0;
    m_write_strb  = '0;
    m_read_ready  = 1'b0;
    s_req_ready   = '0;
    s_write_ready = '0;
    s_read_valid  = '0;
    case (state)
      ST_REQ: begin
        m_req_valid = sel_req_valid;
        m_req_rw    = sel_rw;
        m_req_addr  = sel_addr;
        m_req_burst = sel_burst;
        m_req_beats = sel_beats;
        s_req_ready = m_req_ready ? grant : '0;
      end
      ST_WRITE: begin
        m_write_valid = sel_write_valid;
        m_write_data  = sel_wdata;
        m_write_strb  = sel_wstrb;
        s_write_ready = m_write_ready ? grant : '0;
      end
      ST_READ: begin
        m_read_ready = sel_read_ready;
        s_read_valid = m_read_valid ? grant : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= ST_IDLE;
      grant      <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      beats_left <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            grant <= arb_onehot;
            gidx  <= arb_idx;
            busy  <= 1'b1;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_hs) begin
            beats_left <= (sel_burst && (sel_beats != '0)) ? sel_beats : 14'd1;
            state      <= sel_rw ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE, ST_READ: begin
          if ((wr_hs || rd_hs) && (beats_left != '0)) begin
            beats_left <= beats_left - 14'd1;
            if (beats_left == 14'd1) begin
              state  <= ST_IDLE;
              grant  <= '0;
              busy   <= 1'b0;
              rr_ptr <= rr_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mam_req_arbiter.sv
// Self-checking bench for mam_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_mam_req_arbiter;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int IW = 1;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  always #5 CLK_I = ~CLK_I;

  logic [N-1:0]      s_req_valid, s_req_ready, s_req_rw, s_req_burst;
  logic [N*AW-1:0]   s_req_addr;
  logic [N*14-1:0]   s_req_beats;
  logic [N-1:0]      s_write_valid, s_write_ready, s_read_valid, s_read_ready;
  logic [N*DW-1:0]   s_write_data;
  logic [N*SW-1:0]   s_write_strb;
  logic [DW-1:0]     s_read_data;
  logic              m_req_valid, m_req_ready, m_req_rw, m_req_burst;
  logic [AW-1:0]     m_req_addr;
  logic [13:0]       m_req_beats;
  logic              m_write_valid, m_write_ready, m_read_valid, m_read_ready;
  logic [DW-1:0]     m_write_data, m_read_data;
  logic [SW-1:0]     m_write_strb;
  logic [N-1:0]      grant;
  logic              busy;

  // Per-requester stimulus, packed onto the DUT buses below.
  logic          rq_v [N];
  logic          rq_rw [N];
  logic          rq_burst [N];
  logic [AW-1:0] rq_addr [N];
  logic [13:0]   rq_beats [N];
  logic          wr_v [N];
  logic [DW-1:0] wr_data [N];
  logic [SW-1:0] wr_strb [N];
  logic          rd_rdy [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign s_req_valid[i]           = rq_v[i];
    assign s_req_rw[i]              = rq_rw[i];
    assign s_req_burst[i]           = rq_burst[i];
    assign s_req_addr[i*AW +: AW]   = rq_addr[i];
    assign s_req_beats[i*14 +: 14]  = rq_beats[i];
    assign s_write_valid[i]         = wr_v[i];
    assign s_write_data[i*DW +: DW] = wr_data[i];
    assign s_write_strb[i*SW +: SW] = wr_strb[i];
    assign s_read_ready[i]          = rd_rdy[i];
  end

  mam_req_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
    .s_req_addr(s_req_addr), .s_req_burst(s_req_burst), .s_req_beats(s_req_beats),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_write_ready(s_write_ready), .s_read_valid(s_read_valid), .s_read_data(s_read_data),
    .s_read_ready(s_read_ready),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_rw(m_req_rw),
    .m_req_addr(m_req_addr), .m_req_burst(m_req_burst), .m_req_beats(m_req_beats),
    .m_write_valid(m_write_valid), .m_write_data(m_write_data), .m_write_strb(m_write_strb),
    .m_write_ready(m_write_ready), .m_read_valid(m_read_valid), .m_read_data(m_read_data),
    .m_read_ready(m_read_ready),
    .grant(grant), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: who owns the port, whether the address phase is done, beats still owed.
  logic          mact = 1'b0;
  logic [IW-1:0] mo   = '0;
  logic          mdata = 1'b0;
  logic          mrw  = 1'b0;
  int            mleft = 0;
  int            mrr  = 0;
  logic          en   = 1'b0;

  initial begin
    wait (en);
    forever begin
      logic [N-1:0] e_grant, e_sreq, e_swr, e_srd;
      logic         e_mreq, e_mwr, e_mrd;
      @(negedge CLK_I);
      e_grant = '0; e_sreq = '0; e_swr = '0; e_srd = '0;
      e_mreq = 1'b0; e_mwr = 1'b0; e_mrd = 1'b0;
      if (mact) begin
        e_grant[mo] = 1'b1;
        if (!mdata) begin
          e_mreq = rq_v[mo];
          if (m_req_ready) e_sreq = e_grant;
          chk("m_req_addr", 64'(m_req_addr), 64'(rq_addr[mo]));
          chk("m_req_rw", 64'(m_req_rw), 64'(rq_rw[mo]));
          chk("m_req_beats", 64'(m_req_beats), 64'(rq_beats[mo]));
        end else if (mrw) begin
          e_mwr = wr_v[mo];
          if (m_write_ready) e_swr = e_grant;
          chk("m_write_data", 64'(m_write_data), 64'(wr_data[mo]));
          chk("m_write_strb", 64'(m_write_strb), 64'(wr_strb[mo]));
        end else begin
          e_mrd = rd_rdy[mo];
          if (m_read_valid) e_srd = e_grant;
        end
      end
      chk("grant", 64'(grant), 64'(e_grant));
      chk("busy", 64'(busy), 64'(mact));
      chk("s_req_ready", 64'(s_req_ready), 64'(e_sreq));
      chk("s_write_ready", 64'(s_write_ready), 64'(e_swr));
      chk("s_read_valid", 64'(s_read_valid), 64'(e_srd));
      chk("m_req_valid", 64'(m_req_valid), 64'(e_mreq));
      chk("m_write_valid", 64'(m_write_valid), 64'(e_mwr));
      chk("m_read_ready", 64'(m_read_ready), 64'(e_mrd));
      chk("s_read_data", 64'(s_read_data), 64'(m_read_data));

      if (RST_I) begin
        mact = 1'b0; mdata = 1'b0; mleft = 0; mrr = 0;
      end else if (!mact) begin
        for (int k = 0; k < N; k++) begin
          int p;
          p = (mrr + k) % N;
          if (!mact && rq_v[IW'(p)]) begin
            mact = 1'b1; mo = IW'(p); mdata = 1'b0;
          end
        end
      end else if (!mdata) begin
        if (rq_v[mo] && m_req_ready) begin
          mdata = 1'b1;
          mrw   = rq_rw[mo];
          mleft = (rq_burst[mo] && rq_beats[mo] != 0) ? int'(rq_beats[mo]) : 1;
        end
      end else if ((mrw && wr_v[mo] && m_write_ready) || (!mrw && m_read_valid && rd_rdy[mo])) begin
        mleft--;
        if (mleft == 0) begin
          mact = 1'b0; mdata = 1'b0;
          mrr  = (int'(mo) + 1) % N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      rq_v[i] = 1'b0; rq_rw[i] = 1'b0; rq_burst[i] = 1'b0; rq_addr[i] = '0; rq_beats[i] = '0;
      wr_v[i] = 1'b0; wr_data[i] = '0; wr_strb[i] = '0; rd_rdy[i] = 1'b0;
    end
    m_req_ready = 1'b0; m_write_ready = 1'b0; m_read_valid = 1'b0; m_read_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
  endtask

  initial begin
    int hs;
    clear_inputs();
    RST_I = 1'b1;
    tick();
    tick();
    en = 1'b1;
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    RST_I = 1'b0;

    // Single write from port0
    rq_v[0] = 1'b1; rq_rw[0] = 1'b1; rq_addr[0] = 32'h100; wr_v[0] = 1'b1;
    wr_data[0] = 16'hBEEF; wr_strb[0] = 2'b11; m_req_ready = 1'b1; m_write_ready = 1'b1;
    tick();
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_addr", 64'(m_req_addr), 64'h100);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_wdata", 64'(m_write_data), 64'hBEEF);
    chk("t1_wready", 64'(s_write_ready), 64'h1);
    rq_v[0] = 1'b0;
    tick();
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_grant", 64'(grant), 64'd0);

    // Tie between port0 and port1 after reset
    do_reset();
    rq_v[0] = 1'b1; rq_v[1] = 1'b1; m_req_ready = 1'b1; m_read_valid = 1'b1;
    rd_rdy[0] = 1'b1; rd_rdy[1] = 1'b1;
    tick(); chk("t2_first", 64'(grant), 64'h1);
    tick();
    tick(); chk("t2_gap", 64'(busy), 64'd0);
    tick(); chk("t2_second", 64'(grant), 64'h2);
    tick();
    tick();
    tick(); chk("t2_third", 64'(grant), 64'h1);

    // Port1 read burst of 4 with toggling read_ready
    do_reset();
    rq_v[1] = 1'b1; rq_burst[1] = 1'b1; rq_beats[1] = 14'd4; m_req_ready = 1'b1;
    m_read_valid = 1'b1; rd_rdy[0] = 1'b1;
    tick(); chk("t3_grant", 64'(grant), 64'h2);
    tick();
    rq_v[1] = 1'b0;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      rd_rdy[1] = (c % 2 == 0);
      m_read_data = 16'(c * 7 + 3);
      @(negedge CLK_I);
      if (s_read_valid[1] && rd_rdy[1]) hs++;
      chk("t3_p0_rvalid", 64'(s_read_valid[0]), 64'd0);
      tick();
      if (!busy) break;
    end
    chk("t3_handshakes", 64'(hs), 64'd4);
    chk("t3_done", 64'(busy), 64'd0);

    // Burst with beats=0 behaves as one beat
    do_reset();
    rq_v[0] = 1'b1; rq_rw[0] = 1'b1; rq_burst[0] = 1'b1; rq_beats[0] = 14'd0;
    wr_v[0] = 1'b1; m_req_ready = 1'b1; m_write_ready = 1'b1;
    tick();
    tick();
    rq_v[0] = 1'b0;
    tick(); chk("t4_idle", 64'(busy), 64'd0);

    // Reset during beat 2 of an 8-beat write
    do_reset();
    rq_v[0] = 1'b1; rq_rw[0] = 1'b1; rq_burst[0] = 1'b1; rq_beats[0] = 14'd8;
    wr_v[0] = 1'b1; m_req_ready = 1'b1; m_write_ready = 1'b1;
    tick();
    tick();
    rq_v[0] = 1'b0;
    tick();
    chk("t5_midburst", 64'(busy), 64'd1);
    RST_I = 1'b1;
    tick();
    chk("t5_grant", 64'(grant), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_wready", 64'(s_write_ready), 64'd0);
    chk("t5_rready", 64'(s_req_ready), 64'd0);
    RST_I = 1'b0;

    // Port0 continuous, port1 arrives once
    do_reset();
    rq_v[0] = 1'b1; rq_rw[0] = 1'b1; rq_rw[1] = 1'b1; wr_v[0] = 1'b1; wr_v[1] = 1'b1;
    m_req_ready = 1'b1; m_write_ready = 1'b1;
    tick(); chk("t6_first", 64'(grant), 64'h1);
    rq_v[1] = 1'b1;
    tick();
    tick();
    tick(); chk("t6_port1", 64'(grant), 64'h2);
    rq_v[1] = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      RST_I = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        rq_v[i]     = ($urandom_range(0, 2) == 0);
        rq_rw[i]    = 1'($urandom_range(0, 1));
        rq_burst[i] = 1'($urandom_range(0, 1));
        rq_addr[i]  = $urandom;
        rq_beats[i] = 14'($urandom_range(0, 5));
        wr_v[i]     = ($urandom_range(0, 3) != 0);
        wr_data[i]  = 16'($urandom);
        wr_strb[i]  = 2'($urandom);
        rd_rdy[i]   = ($urandom_range(0, 3) != 0);
      end
      m_req_ready   = ($urandom_range(0, 3) != 0);
      m_write_ready = ($urandom_range(0, 3) != 0);
      m_read_valid  = ($urandom_range(0, 3) != 0);
      m_read_data   = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
